// File: rtl/ethpipe_csr.sv
// Slave-bus control/status register file for the Ethernet pipe: global counter, per-channel DMA
// windows, TX slot pointers and a masked interrupt aggregator. Bus data lanes are byte-swapped.
module ethpipe_csr #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned PTR_W       = 14,
  parameter int unsigned BAR         = 0,
  parameter logic [31:0] DMA_BASE    = 32'h1000_0000,
  parameter logic [31:0] DMA_STRIDE  = 32'h0010_0000,
  parameter logic [21:0] DMA_LEN_RST = 22'h01_0000
) (
  input  logic                 clk_125,
  input  logic                 sys_rst,
  input  logic [6:0]           slv_bar_i,
  input  logic                 slv_ce_i,
  input  logic                 slv_we_i,
  input  logic [19:1]          slv_adr_i,
  input  logic [15:0]          slv_dat_i,
  input  logic [1:0]           slv_sel_i,
  output logic [15:0]          slv_dat_o,
  input  logic [NCH-1:0]       ch_intr_i,
  input  logic [NCH*30-1:0]    dma_cur_i,
  input  logic [NCH*PTR_W-1:0] tx_rd_ptr_i,
  output logic [63:0]          global_counter,
  output logic [NCH*2-1:0]     ch_ctrl_o,
  output logic [NCH*20-1:0]    dma_len_o,
  output logic [NCH*30-1:0]    dma_start_o,
  output logic [NCH*PTR_W-1:0] tx_wr_ptr_o,
  output logic                 sys_intr
);

  localparam logic [2:0] BarIdx = 3'(BAR);

  function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] sel);
    merge16 = old_v;
    if (sel[1]) merge16[7:0] = new_v[7:0];
    if (sel[0]) merge16[15:8] = new_v[15:8];
  endfunction

  logic              access, rd_acc, wr_acc;
  logic [10:0]       w;
  logic [15:0]       wv;
  logic [15:0]       rv;
  logic [15:0]       dat_q;
  logic [63:0]       cnt_q, snap_q;
  logic [NCH-1:0]    pend_q, pend_d, mask_q, clr;
  logic [NCH-1:0]    ch_hit;
  logic [NCH-1:0][15:0] ch_rv;
  logic              unused_bar;

  assign access = slv_ce_i & slv_bar_i[BarIdx] & (slv_adr_i[19:12] == 8'd0);
  assign rd_acc = access & ~slv_we_i;
  assign wr_acc = access & slv_we_i;
  assign w      = slv_adr_i[11:1];
  // Undo the lane swap so wv is in register bit order.
  assign wv     = {slv_dat_i[7:0], slv_dat_i[15:8]};
  assign unused_bar = ^slv_bar_i;

  assign slv_dat_o      = dat_q;
  assign global_counter = cnt_q;
  assign sys_intr       = |(pend_q & mask_q);

  always_comb begin
    clr = '0;
    if (wr_acc && (w == 11'h001) && slv_sel_i[1]) clr = wv[NCH-1:0];
    // A new event in the same cycle as its clear must survive.
    pend_d = (pend_q & ~clr) | ch_intr_i;
  end

  always_comb begin
    rv = '0;
    case (w)
      11'h000: rv = {8'(NCH), 8'hE1};
      11'h001: rv = 16'(pend_q);
      11'h002: rv = 16'(mask_q);
      11'h004: rv = cnt_q[15:0];
      11'h005: rv = snap_q[31:16];
      11'h006: rv = snap_q[47:32];
      11'h007: rv = snap_q[63:48];
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (ch_hit[i]) rv = ch_rv[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q  <= '0;
      snap_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      dat_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 64'd1;
      pend_q <= pend_d;
      if (wr_acc && (w == 11'h002) && slv_sel_i[1]) mask_q <= wv[NCH-1:0];
      if (rd_acc && (w == 11'h004)) snap_q <= cnt_q;
      if (rd_acc) dat_q <= {rv[7:0], rv[15:8]};
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    localparam logic [31:0] StartRst = DMA_BASE + DMA_STRIDE * 32'(n);

    logic [1:0]       ctrl_q;
    logic [19:0]      len_q;
    logic [29:0]      start_q;
    logic [13:0]      start_sh_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [7:0]       wr_sh_q;
    logic [29:0]      cur;
    logic [PTR_W-1:0] rd_ptr, free;
    logic [21:0]      len_b;
    logic [31:0]      start_b, cur_b;
    logic [15:0]      len_lo_m, start_lo_m, start_hi_m, ptr_full, rv_ch;
    logic [3:0]       off;
    logic             wr_hit;
    logic             unused_ch;

    assign off       = w[3:0];
    assign ch_hit[n] = (w[10:4] == 7'(n + 1));
    assign wr_hit    = wr_acc & ch_hit[n];
    assign cur       = dma_cur_i[n*30 +: 30];
    assign rd_ptr    = tx_rd_ptr_i[n*PTR_W +: PTR_W];
    // rd - wr - 1 == rd + ~wr; one slot stays reserved so wr == rd reads as empty.
    assign free      = rd_ptr + ~wr_ptr_q;
    assign len_b     = {len_q, 2'b00};
    assign start_b   = {start_q, 2'b00};
    assign cur_b     = {cur, 2'b00};

    assign len_lo_m   = merge16(len_b[15:0], wv, slv_sel_i);
    assign start_lo_m = merge16({start_sh_q, 2'b00}, wv, slv_sel_i);
    assign start_hi_m = merge16(start_b[31:16], wv, slv_sel_i);
    assign ptr_full   = {wv[15:8], slv_sel_i[1] ? wv[7:0] : wr_sh_q};
    assign unused_ch  = ^{ptr_full, len_lo_m[1:0], start_lo_m[1:0]};

    always_ff @(posedge clk_125 or posedge sys_rst) begin
      if (sys_rst) begin
        ctrl_q     <= '0;
        len_q      <= DMA_LEN_RST[21:2];
        start_q    <= StartRst[31:2];
        start_sh_q <= '0;
        wr_ptr_q   <= '0;
        wr_sh_q    <= '0;
      end else if (wr_hit) begin
        case (off)
          4'h0: if (slv_sel_i[1]) ctrl_q <= wv[1:0];
          4'h2: len_q[13:0] <= len_lo_m[15:2];
          4'h3: if (slv_sel_i[1]) len_q[19:14] <= wv[5:0];
          4'h4: start_sh_q <= start_lo_m[15:2];
          4'h5: start_q <= {start_hi_m, start_sh_q};
          4'h8: begin
            if (slv_sel_i[1]) wr_sh_q <= wv[7:0];
            if (slv_sel_i[0]) wr_ptr_q <= ptr_full[PTR_W-1:0];
          end
          default: ;
        endcase
      end
    end

    always_comb begin
      rv_ch = '0;
      case (off)
        4'h0: rv_ch = {14'd0, ctrl_q};
        4'h2: rv_ch = len_b[15:0];
        4'h3: rv_ch = {10'd0, len_b[21:16]};
        4'h4: rv_ch = start_b[15:0];
        4'h5: rv_ch = start_b[31:16];
        4'h6: rv_ch = cur_b[15:0];
        4'h7: rv_ch = cur_b[31:16];
        4'h8: rv_ch = 16'(wr_ptr_q);
        4'h9: rv_ch = 16'(rd_ptr);
        4'hA: rv_ch = 16'(free);
        default: rv_ch = '0;
      endcase
    end

    assign ch_rv[n]                  = rv_ch;
    assign ch_ctrl_o[n*2 +: 2]       = ctrl_q;
    assign dma_len_o[n*20 +: 20]     = len_q;
    assign dma_start_o[n*30 +: 30]   = start_q;
    assign tx_wr_ptr_o[n*PTR_W +: PTR_W] = wr_ptr_q;
  end

endmodule

// File: tb/tb_ethpipe_csr.sv
// Directed bench for ethpipe_csr: a vector table for single accesses plus hand sequences for
// shadow commits, snapshots, interrupt races and reset during an access.
module tb_ethpipe_csr;
  localparam int unsigned NCH   = 2;
  localparam int unsigned PTR_W = 14;

  logic                 clk_125 = 1'b0;
  logic                 sys_rst;
  logic [6:0]           slv_bar_i;
  logic                 slv_ce_i, slv_we_i;
  logic [19:1]          slv_adr_i;
  logic [15:0]          slv_dat_i;
  logic [1:0]           slv_sel_i;
  logic [15:0]          slv_dat_o;
  logic [NCH-1:0]       ch_intr_i;
  logic [NCH*30-1:0]    dma_cur_i;
  logic [NCH*PTR_W-1:0] tx_rd_ptr_i;
  logic [63:0]          global_counter;
  logic [NCH*2-1:0]     ch_ctrl_o;
  logic [NCH*20-1:0]    dma_len_o;
  logic [NCH*30-1:0]    dma_start_o;
  logic [NCH*PTR_W-1:0] tx_wr_ptr_o;
  logic                 sys_intr;

  ethpipe_csr #(.NCH(NCH), .PTR_W(PTR_W)) dut (
    .clk_125(clk_125), .sys_rst(sys_rst), .slv_bar_i(slv_bar_i), .slv_ce_i(slv_ce_i),
    .slv_we_i(slv_we_i), .slv_adr_i(slv_adr_i), .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i),
    .slv_dat_o(slv_dat_o), .ch_intr_i(ch_intr_i), .dma_cur_i(dma_cur_i),
    .tx_rd_ptr_i(tx_rd_ptr_i), .global_counter(global_counter), .ch_ctrl_o(ch_ctrl_o),
    .dma_len_o(dma_len_o), .dma_start_o(dma_start_o), .tx_wr_ptr_o(tx_wr_ptr_o),
    .sys_intr(sys_intr)
  );

  always #4 clk_125 = ~clk_125;

  // Reference free-running counter.
  logic [63:0] m_cnt;
  always @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst) m_cnt <= '0;
    else         m_cnt <= m_cnt + 64'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [10:0] w;
    logic [1:0]  sel;
    logic [15:0] dat;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [24];

  function automatic logic [15:0] sw(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that captured the access.
  task automatic acc(input logic we, input logic [10:0] w, input logic [1:0] sel,
                     input logic [15:0] dat);
    slv_ce_i  = 1'b1;
    slv_we_i  = we;
    slv_adr_i = {8'h00, w};
    slv_sel_i = sel;
    slv_dat_i = dat;
    @(posedge clk_125);
    #1;
    slv_ce_i = 1'b0;
    slv_we_i = 1'b0;
  endtask

  logic [63:0] exp_snap;

  initial begin
    sys_rst     = 1'b1;
    slv_bar_i   = 7'b000_0001;
    slv_ce_i    = 1'b0;
    slv_we_i    = 1'b0;
    slv_adr_i   = '0;
    slv_dat_i   = '0;
    slv_sel_i   = '0;
    ch_intr_i   = '0;
    dma_cur_i   = {30'h0, 30'h048D_159E};
    tx_rd_ptr_i = '0;

    tbl[0]  = '{1'b0, 11'h000, 2'b00, 16'h0000, 16'hE102};
    tbl[1]  = '{1'b0, 11'h024, 2'b00, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 11'h025, 2'b00, 16'h0000, 16'h1010};
    tbl[3]  = '{1'b0, 11'h015, 2'b00, 16'h0000, 16'h0010};
    tbl[4]  = '{1'b0, 11'h013, 2'b00, 16'h0000, 16'h0100};
    tbl[5]  = '{1'b0, 11'h012, 2'b00, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 11'h010, 2'b10, 16'h0300, 16'h0000};
    tbl[7]  = '{1'b0, 11'h010, 2'b00, 16'h0000, 16'h0300};
    tbl[8]  = '{1'b1, 11'h012, 2'b11, 16'hCCAB, 16'h0000};
    tbl[9]  = '{1'b0, 11'h012, 2'b00, 16'h0000, 16'hCCAB};
    tbl[10] = '{1'b1, 11'h023, 2'b10, 16'h2A00, 16'h0000};
    tbl[11] = '{1'b0, 11'h023, 2'b00, 16'h0000, 16'h2A00};
    tbl[12] = '{1'b0, 11'h003, 2'b00, 16'h0000, 16'h0000};
    tbl[13] = '{1'b0, 11'h035, 2'b00, 16'h0000, 16'h0000};
    tbl[14] = '{1'b1, 11'h035, 2'b11, 16'hFFFF, 16'h0000};
    tbl[15] = '{1'b0, 11'h01B, 2'b00, 16'h0000, 16'h0000};
    tbl[16] = '{1'b0, 11'h016, 2'b00, 16'h0000, 16'h7856};
    tbl[17] = '{1'b0, 11'h017, 2'b00, 16'h0000, 16'h3412};
    tbl[18] = '{1'b1, 11'h002, 2'b10, 16'h0100, 16'h0000};
    tbl[19] = '{1'b0, 11'h002, 2'b00, 16'h0000, 16'h0100};
    tbl[20] = '{1'b1, 11'h000, 2'b11, 16'hFFFF, 16'h0000};
    tbl[21] = '{1'b0, 11'h000, 2'b00, 16'h0000, 16'hE102};
    tbl[22] = '{1'b1, 11'h010, 2'b01, 16'h00FF, 16'h0000};
    tbl[23] = '{1'b0, 11'h010, 2'b00, 16'h0000, 16'h0300};

    repeat (3) @(posedge clk_125);
    #1;
    sys_rst = 1'b0;

    check("rst_dat", 64'(slv_dat_o), 64'h0);
    check("rst_cnt", global_counter, m_cnt);
    check("rst_ctrl", 64'(ch_ctrl_o), 64'h0);
    check("rst_wrptr", 64'(tx_wr_ptr_o), 64'h0);
    check("rst_len", 64'(dma_len_o), 64'({20'h04000, 20'h04000}));
    check("rst_start", 64'(dma_start_o), 64'({30'h0404_0000, 30'h0400_0000}));
    check("rst_intr", 64'(sys_intr), 64'h0);

    for (int i = 0; i < 24; i++) begin
      acc(tbl[i].we, tbl[i].w, tbl[i].sel, tbl[i].dat);
      if (!tbl[i].we) check($sformatf("vec%0d", i), 64'(slv_dat_o), 64'(tbl[i].exp));
    end
    check("ctrl_out", 64'(ch_ctrl_o), 64'h3);
    check("len_out", 64'(dma_len_o), 64'({20'hA8000, 20'h06AF3}));

    // BAR miss: read data must hold.
    slv_bar_i = 7'b000_0000;
    acc(1'b0, 11'h000, 2'b00, 16'h0000);
    check("bar_miss", 64'(slv_dat_o), 64'h0300);
    slv_bar_i = 7'b000_0001;

    // TX write pointer shadow then commit.
    acc(1'b1, 11'h018, 2'b10, 16'h3400);
    check("wrptr_shadow", 64'(tx_wr_ptr_o), 64'h0);
    acc(1'b1, 11'h018, 2'b01, 16'h0012);
    check("wrptr_commit", 64'(tx_wr_ptr_o), 64'h1234);

    // TX free space.
    tx_rd_ptr_i = {14'h0, 14'h0010};
    acc(1'b1, 11'h018, 2'b11, 16'h1000);
    acc(1'b0, 11'h01A, 2'b00, 16'h0000);
    check("free_empty", 64'(slv_dat_o), 64'(sw(16'h3FFF)));
    acc(1'b1, 11'h018, 2'b11, 16'h0F00);
    acc(1'b0, 11'h01A, 2'b00, 16'h0000);
    check("free_full", 64'(slv_dat_o), 64'h0);
    acc(1'b0, 11'h019, 2'b00, 16'h0000);
    check("rdptr", 64'(slv_dat_o), 64'(sw(16'h0010)));

    // Counter snapshot.
    exp_snap = m_cnt;
    acc(1'b0, 11'h004, 2'b00, 16'h0000);
    check("cnt_lo", 64'(slv_dat_o), 64'(sw(exp_snap[15:0])));
    repeat (100) @(posedge clk_125);
    #1;
    check("cnt_live", global_counter, m_cnt);
    acc(1'b0, 11'h005, 2'b00, 16'h0000);
    check("snap_1", 64'(slv_dat_o), 64'(sw(exp_snap[31:16])));
    acc(1'b0, 11'h007, 2'b00, 16'h0000);
    check("snap_3", 64'(slv_dat_o), 64'(sw(exp_snap[63:48])));

    // Interrupts, mask = 01.
    ch_intr_i = 2'b10;
    @(posedge clk_125);
    #1;
    ch_intr_i = 2'b00;
    check("intr_masked", 64'(sys_intr), 64'h0);
    acc(1'b0, 11'h001, 2'b00, 16'h0000);
    check("pend_set", 64'(slv_dat_o), 64'h0200);
    ch_intr_i = 2'b10;
    acc(1'b1, 11'h001, 2'b10, 16'h0200);
    ch_intr_i = 2'b00;
    acc(1'b0, 11'h001, 2'b00, 16'h0000);
    check("pend_set_wins", 64'(slv_dat_o), 64'h0200);
    acc(1'b1, 11'h001, 2'b10, 16'h0200);
    acc(1'b0, 11'h001, 2'b00, 16'h0000);
    check("pend_w1c", 64'(slv_dat_o), 64'h0);
    ch_intr_i = 2'b01;
    @(posedge clk_125);
    #1;
    ch_intr_i = 2'b00;
    check("intr_on", 64'(sys_intr), 64'h1);
    acc(1'b1, 11'h001, 2'b10, 16'h0100);
    check("intr_off", 64'(sys_intr), 64'h0);

    // DMA start shadow, then reset in the middle of a lo write.
    acc(1'b1, 11'h014, 2'b11, 16'hCDAB);
    check("start_shadow", 64'(dma_start_o[29:0]), 64'h0400_0000);
    acc(1'b0, 11'h014, 2'b00, 16'h0000);
    check("start_lo_live", 64'(slv_dat_o), 64'h0);
    slv_ce_i  = 1'b1;
    slv_we_i  = 1'b1;
    slv_adr_i = {8'h00, 11'h014};
    slv_sel_i = 2'b11;
    slv_dat_i = 16'h7856;
    #2 sys_rst = 1'b1;
    @(posedge clk_125);
    #1;
    slv_ce_i = 1'b0;
    slv_we_i = 1'b0;
    sys_rst  = 1'b0;
    check("rst2_start", 64'(dma_start_o), 64'({30'h0404_0000, 30'h0400_0000}));
    check("rst2_ctrl", 64'(ch_ctrl_o), 64'h0);
    check("rst2_cnt", global_counter, m_cnt);
    acc(1'b1, 11'h015, 2'b11, 16'h3412);
    check("start_commit", 64'(dma_start_o), 64'({30'h0404_0000, 30'h048D_0000}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
